// File: rtl/ps2_scan_fifo.sv
// ps2_scan_fifo: PS/2 keyboard receiver that frames and decodes scan codes and buffers them in a FWFT FIFO.
// Latency: the entry is pushed 1 cycle after the stop-bit sample; the line edge reaches the FSM after 2 sync cycles plus FILTER_LEN filter cycles.
// Backpressure: none toward the keyboard; on a full FIFO without a same-cycle pop the code is dropped and overflow sticks.
// Build option: define PS2_PARITY_CHECK_EN to discard frames that fail odd parity.

// ps2_line_filter: 2-flop synchroniser followed by a stability filter for one PS/2 line.
// Latency: 2 sync cycles plus FILTER_LEN stable samples before lvl follows the line.
// Backpressure: none; free-running.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic lvl
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

  logic          meta;
  logic          sync;
  logic [FW-1:0] cnt;

  // Synchronise the line, then accept a new level only after FILTER_LEN identical differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      lvl  <= 1'b1;
      cnt  <= '0;
    end else begin
      meta <= line;
      sync <= meta;
      if (sync == lvl) begin
        cnt <= '0;
      end else if (cnt == FILT_LAST) begin
        lvl <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// scan_fifo: generic first-word-fall-through FIFO; a pop on full frees room for a same-cycle push.
// Latency: a pushed entry is visible at head the cycle after the push edge.
// Backpressure: push on full without pop is dropped and flagged by drop_vld; pop on empty is ignored.
module scan_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop_rdy,
  output logic                       head_vld,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       drop_vld
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_FULL);
  assign head_vld = (count != '0);
  assign do_pop   = pop_rdy && head_vld;
  assign do_push  = push_vld && (!full || do_pop);
  assign drop_vld = push_vld && !do_push;
  assign head_dat = head_vld ? mem[rd_ptr] : '0;

  // Storage array; contents are only observed through head_dat when non-empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module ps2_scan_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ps2c,
  input  logic                            ps2d,
  input  logic                            rd_en,
  output logic                            code_valid,
  output logic [9:0]                      code_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            shift_state,
  output logic                            overflow,
  output logic                            frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  frame_state_t state;
  logic         ps2c_filt;
  logic         ps2d_filt;
  logic         ps2c_filt_d;
  logic         fall_edge;
  logic [7:0]   shreg;
  logic [2:0]   bit_cnt;
  logic [TW-1:0] to_cnt;
  logic         parity_ok;
  logic         byte_vld;
  logic [7:0]   byte_dat;
  logic         ext_flag;
  logic         brk_flag;
  logic         push_vld;
  logic [9:0]   push_dat;
  logic         drop_vld;
  logic         is_prefix;
  logic         is_shift;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
    .clk   (clk),
    .reset (reset),
    .line  (ps2c),
    .lvl   (ps2c_filt)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
    .clk   (clk),
    .reset (reset),
    .line  (ps2d),
    .lvl   (ps2d_filt)
  );

  // Previous filtered clock level, used to find the 1->0 transition.
  always_ff @(posedge clk) begin
    if (reset) ps2c_filt_d <= 1'b1;
    else       ps2c_filt_d <= ps2c_filt;
  end

  assign fall_edge = ps2c_filt_d && !ps2c_filt;

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  // Keyboards send odd parity across the 8 data bits plus the parity bit.
  assign parity_ok = ^{shreg, par_bit};
`else
  assign parity_ok = 1'b1;
`endif

  // Frame FSM: start, 8 data bits LSB first, parity, stop; aborts on bad stop or a stalled clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
      byte_vld  <= 1'b0;
      byte_dat  <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      byte_vld  <= 1'b0;
      if (state != ST_IDLE && !fall_edge && to_cnt == TO_LAST) begin
        state     <= ST_IDLE;
        to_cnt    <= '0;
        frame_err <= 1'b1;
      end else if (fall_edge) begin
        to_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (!ps2d_filt) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {ps2d_filt, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= ps2d_filt;
`endif
            state <= ST_STOP;
          end
          default: begin
            if (ps2d_filt && parity_ok) begin
              byte_vld <= 1'b1;
              byte_dat <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= ST_IDLE;
          end
        endcase
      end else if (state != ST_IDLE) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  assign is_prefix = (byte_dat == 8'hE0) || (byte_dat == 8'hF0);
  assign is_shift  = (byte_dat == 8'h12) || (byte_dat == 8'h59);
  assign push_vld  = byte_vld && !is_prefix;
  assign push_dat  = {ext_flag, brk_flag, byte_dat};

  // Prefix bytes arm the extended/break flags; any other byte consumes them and updates shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
      shift_state <= 1'b0;
    end else if (byte_vld) begin
      if (byte_dat == 8'hE0) begin
        ext_flag <= 1'b1;
      end else if (byte_dat == 8'hF0) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
        if (is_shift) shift_state <= !brk_flag;
      end
    end
  end

  scan_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(10)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (rd_en),
    .head_vld (code_valid),
    .head_dat (code_out),
    .count    (fifo_count),
    .drop_vld (drop_vld)
  );

  // Sticky record that at least one decoded code was lost.
  always_ff @(posedge clk) begin
    if (reset)         overflow <= 1'b0;
    else if (drop_vld) overflow <= 1'b1;
  end
endmodule

// File: tb/tb_ps2_scan_fifo.sv
// tb_ps2_scan_fifo: directed frames through ps2_scan_fifo with hand-computed expectations.
// Latency: each PS/2 bit is 40 clk cycles; checks are taken 1 time unit after a rising edge.
// Backpressure: the bench pops explicitly with single-cycle rd_en pulses.
module tb_ps2_scan_fifo;
  logic       clk;
  logic       reset;
  logic       ps2c;
  logic       ps2d;
  logic       rd_en;
  logic       code_valid;
  logic [9:0] code_out;
  logic [2:0] fifo_count;
  logic       shift_state;
  logic       overflow;
  logic       frame_err;

  int n_cmp;
  int n_fail;
  int err_cnt;
  int err_base;

  ps2_scan_fifo #(
    .FIFO_DEPTH     (4),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .rd_en       (rd_en),
    .code_valid  (code_valid),
    .code_out    (code_out),
    .fifo_count  (fifo_count),
    .shift_state (shift_state),
    .overflow    (overflow),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle frame_err is high, sampled away from the rising edge.
  initial err_cnt = 0;
  always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2d = b;
    wait_cycles(10);
    ps2c = 1'b0;
    wait_cycles(20);
    ps2c = 1'b1;
    wait_cycles(10);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(bad_par ? (^data) : ~(^data));
    send_bit(1'b1);
    wait_cycles(10);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    wait_cycles(1);
    rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0] burst [5];
    logic [9:0] burst_exp [4];
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    ps2c   = 1'b1;
    ps2d   = 1'b1;
    rd_en  = 1'b0;
    wait_cycles(5);

    check("rst_code_valid",  32'(code_valid),  32'h0);
    check("rst_code_out",    32'(code_out),    32'h0);
    check("rst_fifo_count",  32'(fifo_count),  32'h0);
    check("rst_shift_state", 32'(shift_state), 32'h0);
    check("rst_overflow",    32'(overflow),    32'h0);
    check("rst_frame_err",   32'(frame_err),   32'h0);
    reset = 1'b0;
    wait_cycles(5);

    // Plain make code
    err_base = err_cnt;
    send_frame(8'h1C, 1'b0);
    check("1c_valid", 32'(code_valid), 32'h1);
    check("1c_code",  32'(code_out),   32'h01C);
    check("1c_count", 32'(fifo_count), 32'h1);
    pop();
    check("1c_pop_valid", 32'(code_valid), 32'h0);

    // Extended break code
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("e0f075_count", 32'(fifo_count), 32'h1);
    check("e0f075_code",  32'(code_out),   32'h375);
    pop();

    // Shift make then break
    send_frame(8'h12, 1'b0);
    check("shift_make_state", 32'(shift_state), 32'h1);
    check("shift_make_code",  32'(code_out),    32'h012);
    pop();
    send_frame(8'hF0, 1'b0);
    send_frame(8'h12, 1'b0);
    check("shift_brk_state", 32'(shift_state), 32'h0);
    check("shift_brk_code",  32'(code_out),    32'h112);
    check("shift_brk_count", 32'(fifo_count),  32'h1);
    pop();
    check("good_frames_no_err", 32'(err_cnt - err_base), 32'h0);

    // Overflow on a depth-4 FIFO
    burst[0] = 8'h15; burst[1] = 8'h1D; burst[2] = 8'h24; burst[3] = 8'h2D; burst[4] = 8'h2C;
    burst_exp[0] = 10'h015; burst_exp[1] = 10'h01D; burst_exp[2] = 10'h024; burst_exp[3] = 10'h02D;
    for (int i = 0; i < 5; i++) send_frame(burst[i], 1'b0);
    check("ovf_count", 32'(fifo_count), 32'h4);
    check("ovf_flag",  32'(overflow),   32'h1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_pop%0d", i), 32'(code_out), 32'(burst_exp[i]));
      pop();
    end
    check("ovf_drained", 32'(fifo_count), 32'h0);
    pop();
    check("empty_pop_count", 32'(fifo_count), 32'h0);
    check("ovf_sticky",      32'(overflow),   32'h1);

    // Flipped parity
    err_base = err_cnt;
    send_frame(8'h1C, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    check("badpar_err",   32'(err_cnt - err_base), 32'h1);
    check("badpar_count", 32'(fifo_count),         32'h0);
`else
    check("badpar_err",   32'(err_cnt - err_base), 32'h0);
    check("badpar_code",  32'(code_out),           32'h01C);
    check("badpar_count", 32'(fifo_count),         32'h1);
    pop();
`endif

    // Timeout of a stalled frame
    err_base = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("to_no_early_err", 32'(err_cnt - err_base), 32'h0);
    wait_cycles(300);
    check("to_err",   32'(err_cnt - err_base), 32'h1);
    check("to_count", 32'(fifo_count),         32'h0);
    send_frame(8'h32, 1'b0);
    check("to_next_code", 32'(code_out),       32'h032);
    check("to_next_err",  32'(err_cnt - err_base), 32'h1);
    pop();

    // Reset in the middle of a frame
    err_base = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(20);
    check("midrst_overflow", 32'(overflow),   32'h0);
    check("midrst_count",    32'(fifo_count), 32'h0);
    send_frame(8'h32, 1'b0);
    check("midrst_next_code", 32'(code_out),           32'h032);
    check("midrst_no_err",    32'(err_cnt - err_base), 32'h0);
    pop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_scan_fifo.md
PS2_SCAN_FIFO -- requirements
Module: ps2_scan_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of decoded-code entries buffered (power of two, 2..64).
REQ-002 Parameter FILTER_LEN, default 4, consecutive identical clk samples required to accept a new ps2c/ps2d level.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000, clk cycles without a ps2c falling edge before an in-progress frame is aborted.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ps2c  input  1  PS/2 clock line, asynchronous.
REQ-007 ps2d  input  1  PS/2 data line, asynchronous.
REQ-008 rd_en  input  1  pop request for the head FIFO entry.
REQ-009 code_valid  output  1  high while the FIFO is non-empty.
REQ-010 code_out  output  10  head entry {extended, break, scan[7:0]}; meaningful only while code_valid=1.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH+1)  current number of entries.
REQ-012 shift_state  output  1  high while either shift key (0x12 or 0x59) is held.
REQ-013 overflow  output  1  sticky; set when a decoded code is dropped on a full FIFO.
REQ-014 frame_err  output  1  one-cycle pulse per aborted or rejected frame.

Function
REQ-015 ps2c and ps2d SHALL each pass a 2-flop synchroniser, then a FILTER_LEN-sample stability filter; a falling edge is a filtered-ps2c 1->0 transition.
REQ-016 Frame FSM states IDLE, DATA, PARITY, STOP; bits sampled from filtered ps2d on each falling edge.
REQ-017 IDLE->DATA on falling edge with ps2d=0 (start bit); a falling edge with ps2d=1 in IDLE is ignored.
REQ-018 DATA shifts 8 bits LSB first, ->PARITY after the 8th; PARITY samples the parity bit, ->STOP.
REQ-019 STOP with ps2d=1 completes the frame; ps2d=0 aborts with frame_err; both return to IDLE.
REQ-020 In any non-IDLE state, TIMEOUT_CYCLES clk cycles with no falling edge SHALL abort the frame, pulse frame_err, return to IDLE.
REQ-021 Completed byte 0xE0 sets the pending-extended flag, 0xF0 sets pending-break; neither is pushed.
REQ-022 Any other completed byte is pushed as {ext_flag, brk_flag, byte} one cycle after the stop bit sample, then both flags clear.
REQ-023 Byte 0x12 or 0x59 with brk_flag=0 sets shift_state; with brk_flag=1 clears it; the code is still pushed.
REQ-024 FIFO is first-word-fall-through: code_out shows the head entry whenever code_valid=1; rd_en with code_valid=1 pops, next entry appears the following cycle.
REQ-025 rd_en while empty is ignored; fifo_count unchanged.
REQ-026 Push on full without a same-cycle pop SHALL drop the new code and set overflow; push and pop in the same cycle when full SHALL both succeed, count unchanged.
REQ-027 Push and pop in the same cycle when empty: push succeeds, pop ignored, count becomes 1.
REQ-028 Read/write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-029 reset SHALL force FSM to IDLE, clear shift register, bit counter, timeout counter, ext/brk flags, filters to 1, pointers and fifo_count to 0.
REQ-030 Reset outputs: code_valid=0, code_out=0, fifo_count=0, shift_state=0, overflow=0, frame_err=0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame with no frame_err pulse.

Configuration
REQ-032 Macro PS2_PARITY_CHECK_EN defined: a frame whose 8 data bits plus parity bit have even ones-count SHALL be discarded at STOP and frame_err pulsed.
REQ-033 PS2_PARITY_CHECK_EN undefined: parity bit is sampled but ignored; frames pass solely on start/stop validity.

Verification
REQ-034 Frame 0x1C, good parity -> code_valid=1, code_out=0x01C, fifo_count=1; rd_en one cycle -> code_valid=0.
REQ-035 Frames E0, F0, 75 -> single entry code_out=0x375, fifo_count=1.
REQ-036 Frame 12 -> shift_state=1, entry 0x012; frames F0, 12 -> shift_state=0, entry 0x112.
REQ-037 FIFO_DEPTH=4, frames 15,1D,24,2D,2C with no reads -> fifo_count=4, overflow=1, pops return 0x015,0x01D,0x024,0x02D.
REQ-038 With PS2_PARITY_CHECK_EN, frame 0x1C with flipped parity -> one frame_err pulse, fifo_count=0; without macro -> entry 0x01C.
REQ-039 Start plus 4 data bits then ps2c idle > TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; following frame 0x32 -> code_out=0x032.
